// File: rtl/vend_display_ctrl.sv
// Vending-machine 4-digit multiplexed 7-segment display controller.
// Shows live credit, or a selected item's price for a fixed hold time after selection.
module vend_display_ctrl #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_valid,
  input  logic [7:0] sel_price,
  input  logic [7:0] credit,
  output logic [6:0] seg,
  output logic [3:0] an_n,
  output logic       showing_price
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [6:0] GLYPH_P    = 7'b1110011;
  localparam logic [6:0] GLYPH_C    = 7'b0111001;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  typedef enum logic {
    SHOW_CREDIT,
    SHOW_PRICE
  } state_t;

  state_t        state, state_next;
  logic [7:0]    price_reg, price_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [DW-1:0] div_cnt;
  logic [1:0]    digit_idx;
  logic [7:0]    value;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SHOW_CREDIT;
      price_reg <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_next;
      price_reg <= price_next;
      hold_cnt  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    price_next = price_reg;
    hold_next  = hold_cnt;
    case (state)
      SHOW_CREDIT: begin
        if (sel_valid) begin
          state_next = SHOW_PRICE;
          price_next = sel_price;
          hold_next  = HOLD_LAST;
        end
      end
      SHOW_PRICE: begin
        if (sel_valid) begin
          price_next = sel_price;
          hold_next  = HOLD_LAST;
        end else if (hold_cnt == '0) begin
          state_next = SHOW_CREDIT;
        end else begin
          hold_next = hold_cnt - HW'(1);
        end
      end
      default: state_next = SHOW_CREDIT;
    endcase
  end

  // Scan runs free of the FSM so the refresh rate never depends on what is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    value    = (state == SHOW_PRICE) ? price_reg : credit;
    seg_next = '0;
    case (digit_idx)
      2'd3: seg_next = (state == SHOW_PRICE) ? GLYPH_P : GLYPH_C;
      2'd2: seg_next = '0;
      2'd1: seg_next = (value[7:4] == 4'd0) ? 7'b0000000 : glyph(value[7:4]);
      default: seg_next = glyph(value[3:0]);
    endcase
    an_next = ~(4'b0001 << digit_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg           <= '0;
      an_n          <= '1;
      showing_price <= 1'b0;
    end else begin
      seg           <= seg_next;
      an_n          <= an_next;
      showing_price <= (state == SHOW_PRICE);
    end
  end

endmodule
